// File: rtl/sram_block_mover.sv
// Avalon-MM master on SRAM port s2: executes one block copy (read/capture/write
// per word) or block fill per command, reporting progress and a 32-bit additive checksum.
module sram_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Command handshake: a command is taken on any cycle where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while idle, nothing queues.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write,
  output logic [BE_W-1:0]   byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_FILL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_fill;
  logic [ADDR_W:0]     r_idx;
  logic [DATA_W-1:0]   r_data_q;
  logic [ADDR_W:0]     r_words_done;
  logic [DATA_W-1:0]   r_checksum;
  logic [ADDR_W-1:0]   r_address;
  logic                r_chipselect;
  logic                r_write;
  logic [DATA_W-1:0]   r_writedata;

  logic                w_accept;
  logic                w_last;
  logic [ADDR_W:0]     w_idx_nxt;
  logic [ADDR_W-1:0]   w_src_base;
  logic [ADDR_W-1:0]   w_dst_base;
  logic [DATA_W-1:0]   w_fill_base;
  logic [ADDR_W-1:0]   w_address_nxt;
  logic                w_chipselect_nxt;
  logic                w_write_nxt;
  logic [DATA_W-1:0]   w_writedata_nxt;

  assign w_accept = cmd_valid && (r_state == S_IDLE);
  assign w_last   = ((r_idx + ONE) == r_len);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_len == '0) w_state_nxt = S_DONE;
          else if (cmd_op)   w_state_nxt = S_FILL;
          else               w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = S_CAP;
      S_CAP:   w_state_nxt = S_WR;
      S_WR:    w_state_nxt = w_last ? S_DONE : S_RD;
      S_FILL:  w_state_nxt = w_last ? S_DONE : S_FILL;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are computed from the state and index
  // about to be entered; on the accept cycle the bases come straight from cmd_*.
  assign w_idx_nxt   = w_accept ? '0 :
                       ((r_state == S_WR) || (r_state == S_FILL)) ? r_idx + ONE : r_idx;
  assign w_src_base  = w_accept ? cmd_src  : r_src;
  assign w_dst_base  = w_accept ? cmd_dst  : r_dst;
  assign w_fill_base = w_accept ? cmd_fill : r_fill;

  // Output logic
  always_comb begin
    w_address_nxt    = r_address;
    w_chipselect_nxt = 1'b0;
    w_write_nxt      = 1'b0;
    w_writedata_nxt  = r_writedata;
    case (w_state_nxt)
      S_RD: begin
        w_chipselect_nxt = 1'b1;
        w_address_nxt    = w_src_base + w_idx_nxt[ADDR_W-1:0];
      end
      S_WR: begin
        w_chipselect_nxt = 1'b1;
        w_write_nxt      = 1'b1;
        w_address_nxt    = w_dst_base + w_idx_nxt[ADDR_W-1:0];
        w_writedata_nxt  = readdata;
      end
      S_FILL: begin
        w_chipselect_nxt = 1'b1;
        w_write_nxt      = 1'b1;
        w_address_nxt    = w_dst_base + w_idx_nxt[ADDR_W-1:0];
        w_writedata_nxt  = w_fill_base;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
    end else begin
      r_address    <= w_address_nxt;
      r_chipselect <= w_chipselect_nxt;
      r_write      <= w_write_nxt;
      r_writedata  <= w_writedata_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_len        <= '0;
      r_fill       <= '0;
      r_idx        <= '0;
      r_data_q     <= '0;
      r_words_done <= '0;
      r_checksum   <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_accept) begin
        r_src        <= cmd_src;
        r_dst        <= cmd_dst;
        r_len        <= cmd_len;
        r_fill       <= cmd_fill;
        r_words_done <= '0;
        r_checksum   <= '0;
      end else if (r_state == S_WR) begin
        r_words_done <= r_words_done + ONE;
        r_checksum   <= r_checksum + r_data_q;
      end else if (r_state == S_FILL) begin
        r_words_done <= r_words_done + ONE;
        r_checksum   <= r_checksum + r_fill;
      end
      if (r_state == S_CAP) r_data_q <= readdata;
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state == S_RD) || (r_state == S_CAP) ||
                      (r_state == S_WR) || (r_state == S_FILL);
  assign done       = (r_state == S_DONE);
  assign words_done = r_words_done;
  assign checksum   = r_checksum;
  assign address    = r_address;
  assign chipselect = r_chipselect;
  assign write      = r_write;
  assign writedata  = r_writedata;
  assign byteenable = '1;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sram_block_mover.sv
// Bench for sram_block_mover: dual-port SRAM model, array-based reference model,
// expected-result queue popped by a monitor on every done pulse.
module tb_sram_block_mover;

  typedef struct {
    logic [31:0] sum;
    int          words;
    int          lat;
    int          reads;
    int          writes;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [7:0]  cmd_src = '0;
  logic [7:0]  cmd_dst = '0;
  logic [8:0]  cmd_len = '0;
  logic [31:0] cmd_fill = '0;
  logic        busy;
  logic        done;
  logic [8:0]  words_done;
  logic [31:0] checksum;
  logic [7:0]  address;
  logic        chipselect;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  dbg_state;

  logic        s1_we = 1'b0;
  logic [7:0]  s1_addr = '0;
  logic [31:0] s1_wdata = '0;
  bit          s1_bg = 1'b0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q [$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  sram_block_mover dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .busy(busy), .done(done), .words_done(words_done), .checksum(checksum),
    .address(address), .chipselect(chipselect), .write(write),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port SRAM: s2 owned by the DUT (read latency 1), s1 driven by the bench
  always @(posedge clk) begin
    if (chipselect && write) mem[address] <= writedata;
    if (chipselect && !write) readdata <= mem[address];
    if (s1_we) mem[s1_addr] <= s1_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (chipselect && !write) rd_cnt++;
      if (chipselect && write) wr_cnt++;
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("checksum", checksum, e.sum);
          chk("words_done", {23'b0, words_done}, 32'(e.words));
          chk("read_cycles", 32'(rd_cnt), 32'(e.reads));
          chk("write_cycles", 32'(wr_cnt), 32'(e.writes));
          chk("busy_in_done", {31'b0, busy}, 32'd0);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Reference model: ascending word-by-word effect of one command on the SRAM
  task automatic model(input bit op, input int src, input int dst, input int len,
                       input logic [31:0] fill, output exp_t e);
    logic [31:0] v;
    e.sum = 32'd0;
    for (int i = 0; i < len; i++) begin
      v = op ? fill : ref_mem[(src + i) % 256];
      ref_mem[(dst + i) % 256] = v;
      e.sum += v;
    end
    e.words  = len;
    e.reads  = op ? 0 : len;
    e.writes = len;
    e.lat    = (len == 0) ? 1 : (op ? len + 1 : 3 * len + 1);
    e.acc    = 0;
  endtask

  // Driver tasks
  task automatic s1_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    s1_we = 1'b1;
    s1_addr = 8'(addr);
    s1_wdata = data;
    ref_mem[addr] = data;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit op, input int src, input int dst, input int len,
                       input logic [31:0] fill, input bit use_model, output exp_t e);
    bit ok = 1'b0;
    @(negedge clk);
    cmd_op = op;
    cmd_src = 8'(src);
    cmd_dst = 8'(dst);
    cmd_len = 9'(len);
    cmd_fill = fill;
    cmd_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", {31'b0, ok}, 32'd1);
    e.sum = 32'd0; e.words = 0; e.lat = 0; e.reads = 0; e.writes = 0;
    if (use_model) model(op, src, dst, len, fill, e);
    e.acc = cyc;
    if (use_model) exp_q.push_back(e);
  endtask

  task automatic release_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 1'($urandom);
    cmd_src = 8'($urandom);
    cmd_dst = 8'($urandom);
    cmd_len = 9'($urandom);
    cmd_fill = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", {31'b0, ok}, 32'd1);
    exp_q.delete();
  endtask

  task automatic mem_check(input string name);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk(name, 32'(bad), 32'd0);
  endtask

  task automatic run(input bit op, input int src, input int dst, input int len,
                     input logic [31:0] fill, output exp_t e);
    issue(op, src, dst, len, fill, 1'b1, e);
    release_cmd();
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    exp_t e, e2;
    int acc, dc;
    logic [31:0] keep;

    // Preload the SRAM through s1 while the DUT is held in reset
    for (int a = 0; a < 256; a++) s1_write(a, $urandom);
    s1_write(8'h20, 32'd1);
    s1_write(8'h21, 32'd2);
    s1_write(8'h22, 32'd3);
    s1_we = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("rst_words_sum", {23'b0, words_done} | checksum, 32'd0);
    chk("rst_bus", {22'b0, address, chipselect, write}, 32'd0);
    chk("rst_writedata", writedata, 32'd0);
    chk("rst_byteenable", {28'b0, byteenable}, 32'hF);
    reset = 1'b0;

    // Fill of 4 words
    run(1'b1, 0, 8'h10, 4, 32'hA5A5_0001, e);
    chk("tp_fill_sum", checksum, 32'h9694_0004);
    chk("tp_fill_words", {23'b0, words_done}, 32'd4);
    chk("tp_fill_mem", mem[8'h13], 32'hA5A5_0001);
    mem_check("mem_fill");

    // Copy of 3 words
    run(1'b0, 8'h20, 8'h80, 3, 32'd0, e);
    chk("tp_copy_sum", checksum, 32'd6);
    chk("tp_copy_mem", mem[8'h82], 32'd3);
    mem_check("mem_copy");

    // Wrap-around fill; word 0x02 must stay untouched
    keep = mem[2];
    run(1'b1, 0, 8'hFE, 4, 32'd7, e);
    chk("wrap_ff", mem[8'hFF], 32'd7);
    chk("wrap_00", mem[0], 32'd7);
    chk("wrap_untouched", mem[2], keep);
    mem_check("mem_wrap");

    // Zero-length commands, both ops
    run(1'b0, 8'h05, 8'h50, 0, 32'd0, e);
    run(1'b1, 8'h05, 8'h50, 0, 32'h1234_5678, e);
    chk("len0_sum", checksum, 32'd0);
    mem_check("mem_len0");

    // Hold of final values after done
    run(1'b1, 0, 8'h33, 6, 32'h0102_0304, e);
    repeat (3) @(negedge clk);
    chk("hold_sum", checksum, e.sum);
    chk("hold_words", {23'b0, words_done}, 32'(e.words));

    // Reset in the cycle the 2nd write of a 5-word copy would be registered
    issue(1'b0, 8'h30, 8'h90, 5, 32'd0, 1'b0, e);
    acc = e.acc;
    ref_mem[8'h90] = ref_mem[8'h30];
    release_cmd();
    while (cyc < acc + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dc = done_cnt;
    chk("midrst_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_bus", {30'b0, chipselect, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt), 32'(dc));
    mem_check("mem_midrst");
    run(1'b1, 0, 8'h91, 3, $urandom, e);
    mem_check("mem_after_rst");

    // Back-to-back commands with cmd_valid held, s1 writing concurrently
    s1_bg = 1'b1;
    fork
      begin
        while (s1_bg) s1_write(8'h40 + $urandom_range(0, 15), $urandom);
        s1_we = 1'b0;
      end
    join_none
    issue(1'b0, 8'h00, 8'h60, 8, 32'd0, 1'b1, e);
    issue(1'b1, 8'h00, 8'hA0, 5, 32'hCAFE_0000 | 32'($urandom_range(0, 255)), 1'b1, e2);
    chk("b2b_accept", 32'(e2.acc - last_done_cyc), 32'd1);
    release_cmd();
    wait_idle();
    s1_bg = 1'b0;
    repeat (3) @(negedge clk);
    mem_check("mem_b2b");

    // Randomized commands
    for (int t = 0; t < 25; t++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 256) : $urandom_range(1, 12);
      run(1'($urandom), $urandom_range(0, 255), $urandom_range(0, 255), len, $urandom, e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      mem_check("mem_random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
